seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider (shift-subtract) computing quotient and remainder of two WIDTH-bit operands.
- Inverse-operation companion to the array multiplier datapath: the multiplier produces products, this block recovers factors and remainders.
- One quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit. It is reused for multiply-check (product / a == b) in the verification bench.

Parameters:
- WIDTH, 4, operand/result width in bits; supported range 2..16.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy==0
- dividend  input  WIDTH  unsigned numerator; sampled with accepted start
- divisor  input  WIDTH  unsigned denominator; sampled with accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag, set with done when divisor was 0

Behaviour:
- Clock and reset: one clock (clk), rising edge. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal partial remainder, shift register and counter are all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1, capture dividend into the shift register Q, divisor into D, R=0 (WIDTH+1 bits), count=0.
  - Go to CALC; busy=1 from this edge.
- CALC, one iteration per edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}; T = R' - {1'b0,D} (WIDTH+1 bits).
  - If T[WIDTH]==0: R=T and shift 1 into Q LSB. Otherwise: R=R' and shift 0 into Q LSB.
  - count++.
  - On the edge completing iteration WIDTH: load quotient=final Q, remainder=final R[WIDTH-1:0], div_by_zero=(D==0); set done=1, busy=0; go to DONE.
- Latency: the start-sampling edge is edge 0. done is high in the cycle following edge WIDTH (e.g. edge 4 for WIDTH=4). Exactly one cycle wide.
- DONE:
  - With start=1: accept new operands exactly as in IDLE, go to CALC. done drops at that edge, giving back-to-back throughput of one result per WIDTH+1 cycles.
  - With start=0: go to IDLE. done drops.
- Start while busy=1 is ignored; operands are not re-sampled.
- Output holding: quotient, remainder and div_by_zero hold their last values until the next done. They are not cleared on start.
- Divide by zero: no special early exit. Same latency. The algorithm naturally yields quotient=all ones and remainder=dividend; div_by_zero=1.
- Zero dividend: quotient=0, remainder=0, full latency.
- Reset mid-operation (rst_n low in any state): immediate asynchronous return to reset values. No done is produced for the aborted operation.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse -> done only in the cycle after edge 4; quotient=4, remainder=1, div_by_zero=0; busy high from edge 0 to edge 4.
- 15/15 -> q=1, r=0. 7/9 -> q=0, r=7. 0/5 -> q=0, r=0. Exhaustive 16x16 sweep (divisor!=0) against reference model: q=a/b, r=a%b, and q*b+r==a.
- dividend=9, divisor=0 -> done at edge 4; quotient=15, remainder=9, div_by_zero=1. Next op 8/2 -> q=4, r=0, div_by_zero cleared to 0.
- start held high during the done cycle with new operands 14/4 -> CALC entered with no idle gap; second done exactly 5 cycles after the first; q=3, r=2.
- start pulsed with different operands while busy -> ignored; result matches the first operands only; single done pulse.
- rst_n asserted at edge 2 of 12/5 -> all outputs 0 immediately (asynchronously); no done; a fresh 12/5 after release -> q=2, r=2.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//
// Iterative unsigned restoring (shift-subtract) divider. It produces one
// quotient bit per clock and finishes in WIDTH iterations after the operands
// are accepted. It is the inverse companion of the array multiplier in the
// arithmetic unit.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy is low
//   dividend     unsigned numerator, captured with an accepted start
//   divisor      unsigned denominator, captured with an accepted start
//   busy         high while an operation is in progress
//   done         one-cycle pulse; the result outputs are valid in that cycle
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered flag, loaded with done; set when divisor was 0
//
// Timing: the edge that accepts start is edge 0. Edges 1..WIDTH each perform
// one iteration, and the edge that completes iteration WIDTH loads the
// results and raises done. When start is high during the done cycle, new
// operands are taken on the next edge, so one result is produced every
// WIDTH+1 cycles. A start that arrives while busy is high is ignored.
//
// Divide by zero has no early exit. Every trial subtraction succeeds, so the
// quotient is all ones and the remainder equals the dividend.
//
// WIDTH may range from 2 to 16. CNT_W is derived from WIDTH and must not be
// overridden.
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Counter value seen before the edge that completes the last iteration.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  // Registered state.
  state_t             state_r;
  logic [WIDTH-1:0]   q_r;       // dividend shift register, fills with quotient bits
  logic [WIDTH-1:0]   d_r;       // captured divisor
  // Partial remainder. After every iteration it is below the divisor, so its
  // top bit (bit WIDTH of the nominal WIDTH+1-bit value) is always zero and is
  // not stored. The full WIDTH+1-bit width is rebuilt in r_shift_s.
  logic [WIDTH-1:0]   r_r;
  logic [CNT_W-1:0]   cnt_r;

  // Next-state values.
  state_t             state_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   d_s;
  logic [WIDTH-1:0]   r_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               busy_s;
  logic               done_s;
  logic [WIDTH-1:0]   quotient_s;
  logic [WIDTH-1:0]   remainder_s;
  logic               dbz_s;

  // Datapath for one iteration.
  logic [WIDTH:0]     r_shift_s;  // R' = {R, next dividend bit}
  logic [WIDTH:0]     trial_s;    // T  = R' - D; bit WIDTH set means R' < D

  // State and datapath registers, with asynchronous reset to all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      q_r         <= W_ZERO;
      d_r         <= W_ZERO;
      r_r         <= W_ZERO;
      cnt_r       <= CNT_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= W_ZERO;
      remainder   <= W_ZERO;
      div_by_zero <= 1'b0;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      d_r         <= d_s;
      r_r         <= r_s;
      cnt_r       <= cnt_s;
      busy        <= busy_s;
      done        <= done_s;
      quotient    <= quotient_s;
      remainder   <= remainder_s;
      div_by_zero <= dbz_s;
    end
  end

  // Next-state logic and the shift-subtract step.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    d_s         = d_r;
    r_s         = r_r;
    cnt_s       = cnt_r;
    busy_s      = busy;
    done_s      = 1'b0;
    quotient_s  = quotient;
    remainder_s = remainder;
    dbz_s       = div_by_zero;

    r_shift_s   = {r_r, q_r[WIDTH-1]};
    trial_s     = r_shift_s - {1'b0, d_r};

    case (state_r)
      // DONE accepts new operands exactly as IDLE does, which gives
      // back-to-back operation with no idle gap.
      IDLE, DONE: begin
        if (start) begin
          q_s     = dividend;
          d_s     = divisor;
          r_s     = W_ZERO;
          cnt_s   = CNT_ZERO;
          busy_s  = 1'b1;
          state_s = CALC;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end

      CALC: begin
        // Restoring step: keep the difference only when it did not borrow.
        if (!trial_s[WIDTH]) begin
          r_s = trial_s[WIDTH-1:0];
          q_s = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          r_s = r_shift_s[WIDTH-1:0];
          q_s = {q_r[WIDTH-2:0], 1'b0};
        end
        cnt_s = cnt_r + CNT_ONE;

        if (cnt_r == CNT_LAST) begin
          quotient_s  = q_s;
          remainder_s = r_s;
          dbz_s       = (d_r == W_ZERO);
          done_s      = 1'b1;
          busy_s      = 1'b0;
          state_s     = DONE;
        end else begin
          busy_s      = 1'b1;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Directed and random bench for seq_restoring_divider with WIDTH = 4.
// The expected values come from plain integer division, with the
// divide-by-zero rule stated directly: the quotient is all ones and the
// remainder equals the dividend. Outputs are sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net that ends the run if the bench ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference quotient.
  function automatic int ref_q(input int a, input int b);
    if (b == 0) return (1 << W) - 1;
    return a / b;
  endfunction

  // Reference remainder.
  function automatic int ref_r(input int a, input int b);
    if (b == 0) return a;
    return a % b;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (edge 0), then check acceptance.
  task automatic start_op(input int a, input int b);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    tick();
    start    = 1'b0;
    check("accept_busy", int'(busy), 1);
    check("accept_done", int'(done), 0);
  endtask

  // Run edges 1..W and check the result in the done cycle. When poke is in
  // 1..W-1, a start with different operands is presented after that edge
  // (while busy). It must be ignored.
  task automatic finish_op(input int a, input int b, input int poke);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = W'(a);
    bv = W'(b);
    for (int i = 1; i < W; i++) begin
      tick();
      check("calc_busy", int'(busy), 1);
      check("calc_done", int'(done), 0);
      if (i == poke) begin
        start    = 1'b1;
        dividend = av ^ 4'hF;
        divisor  = bv ^ 4'h5;
      end else begin
        start    = 1'b0;
      end
    end
    tick();
    start = 1'b0;
    check("done_pulse", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("quotient", int'(quotient), ref_q(a, b));
    check("remainder", int'(remainder), ref_r(a, b));
    check("div_by_zero", int'(div_by_zero), (b == 0) ? 1 : 0);
    if (b != 0)
      check("q_times_b_plus_r", int'(quotient) * b + int'(remainder), a);
  endtask

  // One idle edge after done: the pulse must have dropped.
  task automatic idle_after();
    tick();
    check("idle_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int a;
    int b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    // Basic case, with busy/done timing checked on every edge.
    start_op(13, 3);
    finish_op(13, 3, 0);
    idle_after();

    // Directed corner cases.
    start_op(15, 15); finish_op(15, 15, 0); idle_after();
    start_op(7, 9);   finish_op(7, 9, 0);   idle_after();
    start_op(0, 5);   finish_op(0, 5, 0);   idle_after();

    // Exhaustive sweep over all nonzero divisors.
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        start_op(x, y);
        finish_op(x, y, 0);
        idle_after();
      end
    end

    // Divide by zero, then check that the flag clears on the next operation.
    start_op(9, 0); finish_op(9, 0, 0); idle_after();
    start_op(8, 2); finish_op(8, 2, 0); idle_after();

    // Back-to-back: start is held through the done cycle.
    start_op(13, 3);
    finish_op(13, 3, 0);
    start_op(14, 4);           // done drops and busy rises at this edge
    finish_op(14, 4, 0);       // second done W+1 cycles after the first
    idle_after();

    // A start while busy must be ignored.
    start_op(6, 4);
    finish_op(6, 4, 1);
    idle_after();
    start_op(6, 4);
    finish_op(6, 4, W - 1);
    idle_after();

    // Asynchronous reset applied just after edge 2 of 12/5.
    start_op(12, 5);
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_quotient", int'(quotient), 0);
    check("arst_remainder", int'(remainder), 0);
    check("arst_dbz", int'(div_by_zero), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_hold_done", int'(done), 0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_done", int'(done), 0);
    start_op(12, 5);
    finish_op(12, 5, 0);
    idle_after();

    // Random operands, with random busy pokes and random back-to-back chaining.
    for (int k = 0; k < 60; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      start_op(a, b);
      finish_op(a, b, int'($urandom_range(0, W - 1)));
      if ($urandom_range(0, 1) == 0)
        idle_after();
    end
    idle_after();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
